// File: rtl/usart_sync_rx_shifter_if.sv
// -----------------------------------------------------------------------------
// usart_sync_rx_shifter_if
// Bus between the synchronous USART receive shifter and its neighbours:
// the SCLK rising-edge detector and the CPU-side register logic.
//   master : drives sclk_rise, rx_line, rx_read, err_clr; observes status.
//   slave  : the shifter; consumes the pulses and drives rx_data, rx_full,
//            busy, frame_err, overrun_err, parity_err.
// -----------------------------------------------------------------------------
interface usart_sync_rx_shifter_if #(
  parameter int DATA_BITS = 8
);
  logic                 sclk_rise;
  logic                 rx_line;
  logic                 rx_read;
  logic                 err_clr;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_full;
  logic                 busy;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 parity_err;

  modport master (
    output sclk_rise, rx_line, rx_read, err_clr,
    input  rx_data, rx_full, busy, frame_err, overrun_err, parity_err
  );

  modport slave (
    input  sclk_rise, rx_line, rx_read, err_clr,
    output rx_data, rx_full, busy, frame_err, overrun_err, parity_err
  );
endinterface

// File: rtl/usart_sync_rx_shifter.sv
// -----------------------------------------------------------------------------
// usart_sync_rx_shifter
// Synchronous-mode USART receive shifter. Advances one bit per SCLK rising
// edge pulse (sclk_rise), framing start / DATA_BITS data (LSB first) /
// optional even parity / stop, then loads a holding register.
//
// Ports:
//   CPU_Clk : system clock, rising edge.
//   CPU_Rst : asynchronous active-high reset; aborts any frame in flight.
//   bus     : usart_sync_rx_shifter_if.slave
//             in : sclk_rise, rx_line, rx_read, err_clr
//             out: rx_data, rx_full, busy, frame_err, overrun_err, parity_err
//
// Configuration macro:
//   USART_SYNC_RX_PARITY_EN : when defined, a parity bit follows the data
//   bits and is checked for even parity; otherwise parity_err is tied low.
// -----------------------------------------------------------------------------
module usart_sync_rx_shifter #(
  parameter int DATA_BITS = 8
) (
  input logic                    CPU_Clk,
  input logic                    CPU_Rst,
  usart_sync_rx_shifter_if.slave bus
);

  localparam int CW = $clog2(DATA_BITS);

`ifdef USART_SYNC_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_e;
`endif

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 full_q, full_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 done;   // stop-bit pulse: frame completes this cycle
  logic                 load;   // completion is accepted into holding reg

`ifdef USART_SYNC_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 pe_q, pe_d;
`endif

  // Frame FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    done    = 1'b0;
`ifdef USART_SYNC_RX_PARITY_EN
    par_d   = par_q;
`endif
    if (bus.sclk_rise) begin
      case (state_q)
        IDLE: begin
          if (!bus.rx_line) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d[cnt_q] = bus.rx_line;
          if (cnt_q == CW'(DATA_BITS-1)) begin
            // Wrap here so the counter never leaves 0..DATA_BITS-1.
            cnt_d = '0;
`ifdef USART_SYNC_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef USART_SYNC_RX_PARITY_EN
        PARITY: begin
          par_d   = bus.rx_line;
          state_d = STOP;
        end
`endif
        STOP: begin
          state_d = IDLE;
          done    = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Completion / CPU side. A read coinciding with completion frees the
  // holding register in time for the new frame, so rx_full stays set.
  always_comb begin
    load   = done && (!full_q || bus.rx_read);
    data_d = load ? shift_q : data_q;
    if (load)             full_d = 1'b1;
    else if (bus.rx_read) full_d = 1'b0;
    else                  full_d = full_q;
    // Error flags: a new error event takes priority over err_clr.
    fe_d = (fe_q & ~bus.err_clr) | (done & ~bus.rx_line);
    ov_d = (ov_q & ~bus.err_clr) | (done & full_q & ~bus.rx_read);
`ifdef USART_SYNC_RX_PARITY_EN
    pe_d = (pe_q & ~bus.err_clr) | (done & (par_q ^ (^shift_q)));
`endif
  end

  always_ff @(posedge CPU_Clk or posedge CPU_Rst) begin
    if (CPU_Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      full_q  <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef USART_SYNC_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      full_q  <= full_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
`ifdef USART_SYNC_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign bus.rx_data     = data_q;
  assign bus.rx_full     = full_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame_err   = fe_q;
  assign bus.overrun_err = ov_q;
`ifdef USART_SYNC_RX_PARITY_EN
  assign bus.parity_err  = pe_q;
`else
  assign bus.parity_err  = 1'b0;
`endif

endmodule
